// File: rtl/mutex_buffer_pkg.sv
// mutex_buffer_pkg: shared limits and free-buffer search helpers for mutex_buffer_n
package mutex_buffer_pkg;
  localparam int MAX_READER_NUM = 6;
  localparam int MAX_BUFF_NUM = MAX_READER_NUM + 2;
  localparam int MAX_IDX_W = $clog2(MAX_BUFF_NUM);
  typedef logic [MAX_BUFF_NUM-1:0] bmp_t;
  typedef struct packed {
    bmp_t oh;
    logic [MAX_IDX_W-1:0] idx;
    logic full;
  } free_t;
  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input bmp_t oh);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < MAX_BUFF_NUM; k++) idx |= oh[k] ? MAX_IDX_W'(k) : '0;
    return idx;
  endfunction
  // Lowest clear bit of busy as one-hot; all-ones busy yields an empty one-hot and full=1.
  function automatic free_t lowest_free(input bmp_t busy);
    free_t f;
    f.oh = ~busy & (busy + 1'b1);
    f.idx = onehot_to_idx(f.oh);
    f.full = &busy;
    return f;
  endfunction
endpackage

// File: rtl/mutex_buffer_n_if.sv
// mutex_buffer_n_if: writer/reader buffer-ownership bus; MUTEX_BUFFER_FRAME_SEQ_EN adds r_seq
interface mutex_buffer_n_if #(
  parameter int ADDR_W = 32,
  parameter int READER_NUM = 2,
  parameter int IDX_W = 3
);
  localparam int BUFF_NUM = READER_NUM + 2;
  logic [BUFF_NUM*ADDR_W-1:0] buf_addr;
  logic w_sof;
  logic wr_done;
  logic [ADDR_W-1:0] w_addr;
  logic [IDX_W-1:0] w_idx;
  logic [READER_NUM-1:0] r_sof;
  logic [READER_NUM-1:0] r_release;
  logic [READER_NUM*ADDR_W-1:0] r_addr;
  logic [READER_NUM*IDX_W-1:0] r_idx;
  logic [READER_NUM-1:0] r_fresh;
  logic alloc_err;
`ifdef MUTEX_BUFFER_FRAME_SEQ_EN
  logic [READER_NUM*16-1:0] r_seq;
`endif
  modport slave (
    input buf_addr, w_sof, r_sof, r_release,
    output wr_done, w_addr, w_idx, r_addr, r_idx, r_fresh, alloc_err
`ifdef MUTEX_BUFFER_FRAME_SEQ_EN
    , output r_seq
`endif
  );
  modport master (
    output buf_addr, w_sof, r_sof, r_release,
    input wr_done, w_addr, w_idx, r_addr, r_idx, r_fresh, alloc_err
`ifdef MUTEX_BUFFER_FRAME_SEQ_EN
    , input r_seq
`endif
  );
endinterface

// File: rtl/mutex_buffer_rd_slot.sv
// mutex_buffer_rd_slot: one reader's held buffer, freshness tracking; MUTEX_BUFFER_FRAME_SEQ_EN adds seq
module mutex_buffer_rd_slot #(
  parameter int ADDR_W = 32,
  parameter int IDX_W = 3,
  parameter int BUFF_NUM = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic sof,
  input  logic rel,
  input  logic w_sof,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [IDX_W-1:0] w_idx,
  input  logic [BUFF_NUM-1:0] w_bmp,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic [IDX_W-1:0] last_idx,
  input  logic [BUFF_NUM-1:0] last_bmp,
`ifdef MUTEX_BUFFER_FRAME_SEQ_EN
  input  logic [15:0] w_seq,
  input  logic [15:0] last_seq,
  output logic [15:0] seq,
`endif
  output logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0] idx,
  output logic [BUFF_NUM-1:0] bmp,
  output logic fresh
);
  logic pending;
  // A frame completing in the same cycle as sof is the one handed over; otherwise the last complete frame.
  always_ff @(posedge clk)
    if (!resetn) begin
      addr <= '0;
      idx <= '0;
      bmp <= '0;
      fresh <= 1'b0;
      pending <= 1'b0;
    end else begin
      addr <= sof ? (w_sof ? w_addr : last_addr) : addr;
      idx <= sof ? (w_sof ? w_idx : last_idx) : idx;
      bmp <= sof ? (w_sof ? w_bmp : last_bmp) : rel ? '0 : bmp;
      fresh <= sof ? (pending | w_sof) : fresh;
      pending <= sof ? 1'b0 : (pending | w_sof);
    end
`ifdef MUTEX_BUFFER_FRAME_SEQ_EN
  // Sequence number travels with the latched buffer.
  always_ff @(posedge clk)
    if (!resetn) seq <= '0;
    else seq <= sof ? (w_sof ? w_seq : last_seq) : seq;
`endif
endmodule

// File: rtl/mutex_buffer_n.sv
// mutex_buffer_n: one-writer / N-reader frame buffer arbiter; MUTEX_BUFFER_FRAME_SEQ_EN adds frame sequence numbers
module mutex_buffer_n
  import mutex_buffer_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_READER_NUM = 2,
  parameter int C_BUFF_IDX_WIDTH = 3
) (
  input logic clk,
  input logic resetn,
  mutex_buffer_n_if.slave bus
);
  localparam int C_BUFF_NUM = C_READER_NUM + 2;
  logic [C_ADDR_WIDTH-1:0] w_addr, last_addr;
  logic [C_BUFF_IDX_WIDTH-1:0] w_idx, last_idx;
  logic [C_BUFF_NUM-1:0] w_bmp, last_bmp, busy;
  logic [C_BUFF_NUM-1:0] r_bmp [C_READER_NUM];
  logic [C_ADDR_WIDTH-1:0] r_addr_a [C_READER_NUM];
  logic [C_BUFF_IDX_WIDTH-1:0] r_idx_a [C_READER_NUM];
  bmp_t busy_pad;
  free_t fr;
  logic none_free, alloc_err;
  assign bus.wr_done = bus.w_sof;
  assign bus.w_addr = w_addr;
  assign bus.w_idx = w_idx;
  assign bus.alloc_err = alloc_err;
  assign none_free = fr.full | (|(fr.oh >> C_BUFF_NUM));
  // Buffers held by the writer or any reader; bits beyond the pool read as busy.
  always_comb begin
    busy = w_bmp;
    for (int i = 0; i < C_READER_NUM; i++) busy |= r_bmp[i];
    busy_pad = '1;
    busy_pad[C_BUFF_NUM-1:0] = busy;
    fr = lowest_free(busy_pad);
  end
  // Writer rotation: retire current buffer as last complete, claim the lowest free one.
  always_ff @(posedge clk)
    if (!resetn) begin
      w_addr <= bus.buf_addr[C_ADDR_WIDTH +: C_ADDR_WIDTH];
      w_idx <= C_BUFF_IDX_WIDTH'(1);
      w_bmp <= C_BUFF_NUM'(2);
      last_addr <= bus.buf_addr[0 +: C_ADDR_WIDTH];
      last_idx <= '0;
      last_bmp <= C_BUFF_NUM'(1);
      alloc_err <= 1'b0;
    end else if (bus.w_sof) begin
      last_addr <= w_addr;
      last_idx <= w_idx;
      last_bmp <= w_bmp;
      w_addr <= none_free ? bus.buf_addr[C_ADDR_WIDTH +: C_ADDR_WIDTH]
                          : bus.buf_addr[int'(fr.idx)*C_ADDR_WIDTH +: C_ADDR_WIDTH];
      w_idx <= none_free ? C_BUFF_IDX_WIDTH'(1) : C_BUFF_IDX_WIDTH'(fr.idx);
      w_bmp <= none_free ? C_BUFF_NUM'(2) : fr.oh[C_BUFF_NUM-1:0];
      alloc_err <= alloc_err | none_free;
    end
`ifdef MUTEX_BUFFER_FRAME_SEQ_EN
  logic [15:0] seq, last_seq;
  logic [15:0] r_seq_a [C_READER_NUM];
  // Frame counter; the number of the completed frame moves into last on each w_sof.
  always_ff @(posedge clk)
    if (!resetn) begin
      seq <= '0;
      last_seq <= '0;
    end else if (bus.w_sof) begin
      seq <= seq + 16'd1;
      last_seq <= seq;
    end
`endif
  for (genvar i = 0; i < C_READER_NUM; i++) begin : g_rd
    mutex_buffer_rd_slot #(
      .ADDR_W(C_ADDR_WIDTH),
      .IDX_W(C_BUFF_IDX_WIDTH),
      .BUFF_NUM(C_BUFF_NUM)
    ) u_slot (
      .clk(clk),
      .resetn(resetn),
      .sof(bus.r_sof[i]),
      .rel(bus.r_release[i]),
      .w_sof(bus.w_sof),
      .w_addr(w_addr),
      .w_idx(w_idx),
      .w_bmp(w_bmp),
      .last_addr(last_addr),
      .last_idx(last_idx),
      .last_bmp(last_bmp),
`ifdef MUTEX_BUFFER_FRAME_SEQ_EN
      .w_seq(seq),
      .last_seq(last_seq),
      .seq(r_seq_a[i]),
`endif
      .addr(r_addr_a[i]),
      .idx(r_idx_a[i]),
      .bmp(r_bmp[i]),
      .fresh(bus.r_fresh[i])
    );
    assign bus.r_addr[i*C_ADDR_WIDTH +: C_ADDR_WIDTH] = r_addr_a[i];
    assign bus.r_idx[i*C_BUFF_IDX_WIDTH +: C_BUFF_IDX_WIDTH] = r_idx_a[i];
`ifdef MUTEX_BUFFER_FRAME_SEQ_EN
    assign bus.r_seq[i*16 +: 16] = r_seq_a[i];
`endif
  end
endmodule

// File: doc/mutex_buffer_n.md
Name: mutex_buffer_n

Overview:
Parametrised triple-buffer-style frame arbiter for one writer and C_READER_NUM independent readers sharing C_READER_NUM+2 frame buffers in DDR.
- On each writer start-of-frame it retires the buffer just written as "latest complete" and allocates a fresh buffer that no reader holds.
- Readers latch the latest complete buffer at their own start-of-frame.
- Sits between the VDMA/stream-to-mm writer and the per-display reader address ports.
- New relative to the fixed two-reader generation: explicit reader release, a per-reader freshness flag and a sticky allocation-error flag.

Parameters:
- C_ADDR_WIDTH, 32, buffer base address width.
- C_READER_NUM, 2, number of readers, legal 1..6.
- C_BUFF_IDX_WIDTH, 3, index width; must satisfy 2^C_BUFF_IDX_WIDTH >= C_READER_NUM+2.
- Derived localparam C_BUFF_NUM = C_READER_NUM+2.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- buf_addr  in  C_BUFF_NUM*C_ADDR_WIDTH  base addresses; buffer k occupies slice k.
- w_sof  in  1  writer start-of-frame pulse; the previous frame is complete.
- wr_done  out  1  equals w_sof (combinational).
- w_addr  out  C_ADDR_WIDTH  buffer currently owned by the writer.
- w_idx  out  C_BUFF_IDX_WIDTH  index of w_addr.
- r_sof  in  C_READER_NUM  per-reader start-of-frame pulse.
- r_release  in  C_READER_NUM  per-reader release pulse; the reader stops holding its buffer.
- r_addr  out  C_READER_NUM*C_ADDR_WIDTH  per-reader buffer address.
- r_idx  out  C_READER_NUM*C_BUFF_IDX_WIDTH  per-reader buffer index.
- r_fresh  out  C_READER_NUM  1 = the buffer latched at the last r_sof holds a frame not previously delivered to this reader.
- alloc_err  out  1  sticky: the writer found no free buffer.

Behaviour:
- Reset (resetn=0 at posedge):
  - w_addr=buf_addr[1], w_idx=1, w_bmp=one-hot(1).
  - last_addr=buf_addr[0], last_idx=0, last_bmp=one-hot(0).
  - All r_addr=0, r_idx=0, r_bmp=0, r_fresh=0, pending=0, alloc_err=0.
  - Reset mid-frame discards all ownership immediately; no drain.
- All outputs except wr_done are registered; latency is 1 cycle from a pulse to the updated output.
- Writer, on w_sof:
  - last <= current w (addr/idx/bmp).
  - New w = lowest index k with bit k clear in (w_bmp | OR of all r_bmp), all terms sampled before the edge.
  - Busy vector all-ones: w <= buffer 1 and alloc_err <= 1.
- Reader i, on r_sof[i]:
  - If w_sof is also high, latch the current w (the frame completing this cycle). Otherwise latch last.
  - r_fresh[i] <= pending[i] | w_sof; pending[i] <= 0.
- pending[i]:
  - Set by w_sof when r_sof[i] is not high in the same cycle.
  - Cleared by r_sof[i] or reset.
  - Repeated r_sof with no intervening w_sof gives r_fresh=0 and the same buffer.
- r_release[i] clears r_bmp[i] only; r_addr/r_idx hold their values. If r_sof[i] is high in the same cycle, r_sof wins.
- Mutual exclusion invariant: w_bmp is never equal to any r_bmp while that r_bmp is non-zero. With ≤C_READER_NUM readers holding, alloc_err is unreachable.
- w_sof in consecutive cycles is legal; each pulse rotates the buffers.

Optional Feature:
MUTEX_BUFFER_FRAME_SEQ_EN
- Defined:
  - Adds a 16-bit frame counter, reset 0, incremented (wrapping) on each w_sof.
  - The counter is stored with last.
  - Adds output r_seq (C_READER_NUM*16), latched alongside r_addr, so each reader knows the sequence number of its frame.
  - 0xFFFF wraps to 0x0000.
- Undefined: no counter and no r_seq port. All other behaviour is identical.

Decomposition:
- Package mutex_buffer_pkg:
  - MAX_READER_NUM=6.
  - Function lowest_free(busy) returning a one-hot vector plus index.
  - Function onehot_to_idx.
- Sub-module mutex_buffer_rd_slot:
  - One instance per reader via generate.
  - Holds r_addr/r_idx/r_bmp/pending/r_fresh.
  - Inputs: sof, release, w_sof, current w and last tuples.

Test Plan:
- Reset, then 4 w_sof with no readers (C_READER_NUM=2) -> w_idx sequence 0,1,0,1; last_idx follows 1,0,1,0; alloc_err=0.
- r_sof[0] alone after reset -> r_idx0=0, r_addr0=buf_addr[0], r_fresh0=0. Next w_sof -> w_idx skips 0 and becomes 2.
- r_sof[0] and w_sof in the same cycle with w_idx=1 -> r_idx0=1, r_fresh0=1, last_idx=1. New w_idx is 0, never 1.
- Reader 0 holds idx 0 and reader 1 holds idx 2; w_sof repeatedly -> w alternates 1,3 and never 0 or 2. After r_release[0], the next allocation may take 0.
- Two r_sof[1] with no w_sof between -> the second gives the same r_idx and r_fresh1=0. One w_sof then r_sof[1] -> r_fresh1=1.
- Random 10k-cycle stimulus, C_READER_NUM=4 -> assert mutual exclusion every cycle and alloc_err=0. With MUTEX_BUFFER_FRAME_SEQ_EN, r_seq is monotonic per reader modulo wrap.
